// File: rtl/alu_pkg.sv
// alu_pkg: shared code width, decoder state encoding and one-hot helper
package alu_pkg;
  localparam int N = 4;
  localparam int W = 1 << N;
  typedef enum logic {IDLE, SWEEP} state_t;
  function automatic logic [W-1:0] onehot(input logic [N-1:0] code, input logic en);
    return en ? {{(W-1){1'b0}}, 1'b1} << code : '0;
  endfunction
endpackage

// File: rtl/binary_decoder_core.sv
// binary_decoder_core: combinational N-to-2**N one-hot decoder with enable
module binary_decoder_core
  import alu_pkg::*;
(
  input  logic [N-1:0] code,
  input  logic         en,
  output logic [W-1:0] onehot_out
);
  assign onehot_out = onehot(code, en);
endmodule

// File: rtl/binary_decoder_seq.sv
// binary_decoder_seq: registered one-hot decoder with valid/ready handshake and self-test sweep
module binary_decoder_seq
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] binaryIn,
  input  logic         sweep_start,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] decoderOut,
  output logic         busy
);
  state_t       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] data_q, data_d, dec;
  logic         free, take_in, sweep_beat, load;
  // handshake qualifiers: the output slot is free when empty or being drained
  always_comb begin
    free       = !out_valid_q || out_ready;
    in_ready   = (state_q == IDLE) && free;
    take_in    = in_valid && in_ready;
    sweep_beat = (state_q == SWEEP) && free;
    load       = take_in || sweep_beat;
  end
  binary_decoder_core u_core (
    .code       (state_q == SWEEP ? cnt_q : binaryIn),
    .en         (enable),
    .onehot_out (dec)
  );
  // next state: a same-cycle input transfer wins over sweep_start; sweep ends after loading the last code
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    data_d      = load ? dec : data_q;
    if (state_q == IDLE) begin
      if (sweep_start && !take_in) begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
    end else if (free) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == '1) ? IDLE : SWEEP;
    end
  end
  // state and output registers; reset drops any in-flight beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
    end
  end
  assign out_valid  = out_valid_q;
  assign decoderOut = data_q;
  assign busy       = (state_q == SWEEP);
endmodule

// File: doc/binary_decoder_seq.md
# binary_decoder_seq

Registered binary-to-one-hot decoder: the inverse of the 16-to-4 encoder in the ALU datapath. It accepts a 4-bit code over a valid/ready handshake and presents the matching one-hot 16-bit word from an output register. A built-in sweep mode emits all 16 one-hot words in order, which exercises the downstream encoder in self-test. For every code n, encoding the decoder's output returns n.

## Interface
- N, 4, input code width; the output width is 2**N.
- clk  input  1  rising-edge clock; the only clock in the block.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  decode enable; when low, a loaded beat carries all-zero data.
- in_valid  input  1  upstream presents binaryIn.
- in_ready  output  1  block accepts binaryIn this cycle.
- binaryIn  input  N  code to decode.
- sweep_start  input  1  request a 16-beat sweep of codes 0..2**N-1.
- out_valid  output  1  decoderOut holds a beat.
- out_ready  input  1  downstream consumes the beat.
- decoderOut  output  2**N  registered one-hot word.
- busy  output  1  sweep in progress.

## Operation
- FSM states:
  - IDLE: reset state.
  - SWEEP: entered from IDLE when sweep_start=1 and no input transfer occurs that cycle. The counter cnt is set to 0 on entry.
- Slot free: `free = !out_valid || out_ready`.
- in_ready = (state==IDLE) && free. It is combinational and does not depend on sweep_start.
- Input transfer (in_valid && in_ready):
  - decoderOut <= enable ? (1 << binaryIn) : 0.
  - out_valid <= 1.
- Code 0 decodes to 16'h0001. All 16 codes are legal; there is no invalid input.
- Sweep beat (state==SWEEP && free):
  - decoderOut <= enable ? (1 << cnt) : 0.
  - out_valid <= 1.
  - cnt <= cnt+1.
  - On loading cnt==2**N-1, return to IDLE. The counter wraps to 0 and is unused in IDLE.
- Output drain: out_valid && out_ready && no new load → out_valid <= 0. decoderOut keeps its last value.
- Stall: while out_valid && !out_ready, decoderOut and out_valid hold stable and nothing new loads.
- busy = (state==SWEEP).
- Simultaneous in_valid transfer and sweep_start in IDLE: the transfer wins and sweep_start is ignored. The requester must re-assert it.
- sweep_start is ignored in SWEEP.
- in_valid is ignored in SWEEP because in_ready is low there.
- enable is sampled at each load only. Toggling enable mid-stall does not change the held decoderOut.
- Reset, including mid-sweep or mid-stall: the state returns to IDLE immediately and the in-flight beat is dropped.

## Timing
- Reset values:
  - decoderOut = 0
  - out_valid = 0
  - busy = 0
  - cnt = 0
  - in_ready = 1 (combinational: IDLE and slot free)
- Input latency: out_valid rises in the cycle after the accepting edge, so the beat is visible 1 cycle after the transfer.
- Throughput: 1 beat per cycle with out_ready held high, in both input and sweep modes.
- Sweep latency:
  - sweep_start sampled at edge t → busy=1 after t.
  - The first beat (16'h0001) is loaded at edge t+1.
  - The last beat (16'h8000) is loaded at edge t+16 with out_ready continuously high.
  - busy falls after edge t+16.
- Back-to-back: in_ready can be high again in the cycle busy falls, provided out_ready frees the slot.

## Structure
- Shared package (alu_pkg) holds:
  - the code-width constant N (default 4)
  - the state enum {IDLE, SWEEP}
  - a pure function onehot(code, en) returning en ? 1<<code : 0
- The encoder reuses the same constant.
- One sub-module, binary_decoder_core, is natural: purely combinational, N in → 2**N out, with enable. The sequential wrapper instantiates it once, muxing binaryIn or cnt into its input.
- No other hierarchy.

## Test plan
- **Reset:** assert rst_n=0 mid-stall with out_valid=1 → decoderOut=0, out_valid=0, in_ready=1 within the same cycle, before any clock edge.
- **Exhaustive single transfers:** enable=1, out_ready=1, binaryIn=0..15 → decoderOut=16'h0001..16'h8000 one cycle later. Feeding decoderOut into the encoder must return the same binaryIn.
- **Backpressure:** accept binaryIn=5 (decoderOut=16'h0020), hold out_ready=0 for 4 cycles while driving binaryIn=9 → in_ready=0 and decoderOut stays 16'h0020. On out_ready=1, 16'h0200 is loaded the next cycle.
- **Sweep:** sweep_start pulse, out_ready=1 → busy high for 16 cycles; beats 16'h0001,16'h0002,…,16'h8000 on consecutive cycles; then busy=0 and in_ready=1.
- **Sweep with stalls and enable:** out_ready toggling every other cycle and enable=0 → 16 all-zero beats, each held during stalls, in_ready=0 throughout. rst_n pulse at beat 7 → IDLE, busy=0, out_valid=0.
- **Simultaneous events:** sweep_start and in_valid (binaryIn=3) in the same IDLE cycle → 16'h0008 delivered, busy stays 0, no sweep starts.
